// File: rtl/pipe_stall_ctrl.sv
// Pipeline sequencer: arbitrates decode/execute stall requests and flush redirects into a per-stage hold vector.
// Optional saturating performance counters are enabled by defining PIPE_STALL_PERF_EN.
module pipe_stall_ctrl #(
  parameter int LAT_W  = 6,
  parameter int ADDR_W = 32,
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_id,
  input  logic              ex_start,
  input  logic [LAT_W-1:0]  ex_lat,
  input  logic              flush_req,
  input  logic [ADDR_W-1:0] flush_pc,
  output logic [5:0]        stall,
  output logic              flush,
  output logic [ADDR_W-1:0] new_pc,
  output logic              ex_busy,
  output logic [PERF_W-1:0] perf_stall_cnt,
  output logic [PERF_W-1:0] perf_flush_cnt
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    EX_WAIT = 2'd1,
    FLUSH   = 2'd2
  } state_t;

  localparam logic [5:0]       HOLD_ALL = 6'b111111;
  localparam logic [5:0]       HOLD_EX  = 6'b001111;
  localparam logic [5:0]       HOLD_ID  = 6'b000111;
  localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);

  state_t            state_q, state_d;
  logic [LAT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] pc_q, pc_d;

  // Outputs are combinational so a request holds the pipe in the cycle it is raised.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    stall   = '0;
    flush   = 1'b0;
    new_pc  = '0;
    ex_busy = 1'b0;
    case (state_q)
      RUN: begin
        if (flush_req) begin
          stall   = HOLD_ALL;
          state_d = FLUSH;
          pc_d    = flush_pc;
          cnt_d   = '0;
        end else if (ex_start && (ex_lat != '0)) begin
          stall   = HOLD_EX;
          ex_busy = 1'b1;
          // The start cycle is the first stall cycle, so only ex_lat-1 remain.
          if (ex_lat != LAT_ONE) begin
            cnt_d   = ex_lat - LAT_ONE;
            state_d = EX_WAIT;
          end
        end else if (stallreq_id) begin
          stall = HOLD_ID;
        end
      end
      EX_WAIT: begin
        ex_busy = 1'b1;
        if (flush_req) begin
          stall   = HOLD_ALL;
          state_d = FLUSH;
          pc_d    = flush_pc;
          cnt_d   = '0;
        end else begin
          stall = HOLD_EX;
          cnt_d = cnt_q - LAT_ONE;
          if (cnt_q == LAT_ONE) begin
            state_d = RUN;
          end
        end
      end
      FLUSH: begin
        flush  = 1'b1;
        new_pc = pc_q;
        // A repeated request extends the flush and the newest target wins.
        if (flush_req) begin
          pc_d = flush_pc;
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
    end
  end

`ifdef PIPE_STALL_PERF_EN
  localparam logic [PERF_W-1:0] PERF_ONE = PERF_W'(1);

  logic [PERF_W-1:0] perf_stall_q, perf_flush_q;

  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + PERF_ONE : v;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_stall_q <= sat_inc(perf_stall_q, stall != '0);
      perf_flush_q <= sat_inc(perf_flush_q, flush);
    end
  end

  assign perf_stall_cnt = perf_stall_q;
  assign perf_flush_cnt = perf_flush_q;
`else
  assign perf_stall_cnt = '0;
  assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: a cycle-level reference model queues expected outputs, a monitor compares them.
module tb_pipe_stall_ctrl;
  localparam int LAT_W    = 6;
  localparam int ADDR_W   = 32;
  localparam int PERF_W   = 4;
  localparam int PERF_MAX = (1 << PERF_W) - 1;

  logic              clk = 1'b0;
  logic              rst, stallreq_id, ex_start, flush_req;
  logic [LAT_W-1:0]  ex_lat;
  logic [ADDR_W-1:0] flush_pc;
  logic [5:0]        stall;
  logic              flush, ex_busy;
  logic [ADDR_W-1:0] new_pc;
  logic [PERF_W-1:0] perf_stall_cnt, perf_flush_cnt;

  pipe_stall_ctrl #(.LAT_W(LAT_W), .ADDR_W(ADDR_W), .PERF_W(PERF_W)) dut (
    .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .ex_start(ex_start), .ex_lat(ex_lat),
    .flush_req(flush_req), .flush_pc(flush_pc), .stall(stall), .flush(flush), .new_pc(new_pc),
    .ex_busy(ex_busy), .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]        stall;
    logic              flush;
    logic [ADDR_W-1:0] new_pc;
    logic              busy;
    logic [PERF_W-1:0] ps;
    logic [PERF_W-1:0] pf;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  // Reference model: remaining EX hold cycles, pending flush and its target, event counts.
  int                ex_rem  = 0;
  bit                fl_pend = 1'b0;
  logic [ADDR_W-1:0] fl_pc   = '0;
  int                ps_m    = 0;
  int                pf_m    = 0;

  task automatic cyc(input bit r, input bit sr, input bit es, input int el,
                     input bit fr, input logic [ADDR_W-1:0] fpc);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; stallreq_id = sr; ex_start = es; ex_lat = LAT_W'(el);
    flush_req = fr; flush_pc = fpc;
    if (r) begin
      ex_rem = 0; fl_pend = 1'b0; fl_pc = '0; ps_m = 0; pf_m = 0;
      return;
    end
    e.stall = '0; e.flush = 1'b0; e.new_pc = '0; e.busy = 1'b0;
`ifdef PIPE_STALL_PERF_EN
    e.ps = PERF_W'(ps_m);
    e.pf = PERF_W'(pf_m);
`else
    e.ps = '0;
    e.pf = '0;
`endif
    if (fl_pend) begin
      e.flush = 1'b1; e.new_pc = fl_pc; ex_rem = 0;
      if (fr) fl_pc = fpc;
      else fl_pend = 1'b0;
    end else if (fr) begin
      e.stall = 6'b111111; e.busy = (ex_rem > 0);
      ex_rem = 0; fl_pend = 1'b1; fl_pc = fpc;
    end else if (ex_rem > 0) begin
      e.stall = 6'b001111; e.busy = 1'b1; ex_rem--;
    end else if (es && el > 0) begin
      e.stall = 6'b001111; e.busy = 1'b1; ex_rem = el - 1;
    end else if (sr) begin
      e.stall = 6'b000111;
    end
    if (e.stall != 0 && ps_m < PERF_MAX) ps_m++;
    if (e.flush && pf_m < PERF_MAX) pf_m++;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, '0);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  // Monitor: outputs are presented every cycle; compare mid-cycle against the queued expectation.
  initial begin
    forever begin
      exp_t e;
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("stall",   64'(stall),          64'(e.stall));
        chk("flush",   64'(flush),          64'(e.flush));
        chk("new_pc",  64'(new_pc),         64'(e.new_pc));
        chk("ex_busy", 64'(ex_busy),        64'(e.busy));
        chk("perf_stall_cnt", 64'(perf_stall_cnt), 64'(e.ps));
        chk("perf_flush_cnt", 64'(perf_flush_cnt), 64'(e.pf));
      end
    end
  end

  initial begin
    rst = 1'b1; stallreq_id = 1'b0; ex_start = 1'b0; ex_lat = '0;
    flush_req = 1'b0; flush_pc = '0;

    cyc(1, 0, 0, 0, 0, '0);
    cyc(1, 0, 0, 0, 0, '0);
    idle(4);

    cyc(0, 1, 0, 0, 0, '0);
    cyc(0, 1, 0, 0, 0, '0);
    idle(2);

    cyc(0, 0, 1, 4, 0, '0);
    cyc(0, 0, 0, 0, 0, '0);
    cyc(0, 1, 0, 0, 0, '0);
    idle(3);
    cyc(0, 0, 1, 1, 0, '0);
    idle(1);
    cyc(0, 0, 1, 0, 0, '0);
    idle(1);

    cyc(0, 0, 1, 10, 0, '0);
    idle(3);
    cyc(0, 0, 0, 0, 1, 32'hBFC00380);
    idle(3);

    cyc(0, 0, 0, 0, 1, 32'h100);
    cyc(0, 0, 0, 0, 1, 32'h200);
    idle(3);

    // Reset in the middle of a long EX op, then a small known set of events.
    cyc(1, 0, 0, 0, 0, '0);
    idle(1);
    cyc(0, 0, 1, 10, 0, '0);
    idle(4);
    cyc(1, 0, 0, 0, 0, '0);
    idle(2);
    cyc(0, 1, 0, 0, 0, '0);
    cyc(0, 1, 0, 0, 0, '0);
    cyc(0, 0, 0, 0, 1, 32'h0000_1234);
    idle(3);

    // Push both counters into saturation.
    for (int i = 0; i < 20; i++) cyc(0, 1, 0, 0, 0, '0);
    for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0, 1, 32'(i * 4));
    idle(3);
    cyc(0, 0, 1, 63, 0, '0);
    idle(66);

    for (int i = 0; i < 2000; i++) begin
      bit r, sr, es, fr;
      int el;
      r  = ($urandom_range(0, 99) < 1);
      fr = ($urandom_range(0, 99) < 6);
      es = ($urandom_range(0, 99) < 20);
      sr = ($urandom_range(0, 99) < 30);
      el = ($urandom_range(0, 19) == 0) ? 63 : int'($urandom_range(0, 12));
      cyc(r, sr, es, el, fr, $urandom);
    end
    idle(3);

    repeat (3) @(posedge clk);
    #1;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
